// File: rtl/l3_data_arb.sv
`default_nettype none
// ============================================================================
// Module      : l3_data_arb
// Description : Round-robin arbiter and sequencer in front of the L3 data
//               array SRAM. One array access per cycle, shared between
//               N_REQ requesters, with a 1-cycle read response path and a
//               hardware zero sweep over every set and way.
// Revision    : 1.0 - initial release
// ============================================================================
module l3_data_arb #(
  parameter int N_REQ       = 4,
  parameter int WAYS        = 16,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 512,
  localparam int WORDS      = DATA_WIDTH / 64,
  localparam int WAY_W      = $clog2(WAYS),
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // requester side
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_write,
  input  logic [INDEX_WIDTH-1:0] req_index [N_REQ],
  input  logic [WAY_W-1:0]       req_way   [N_REQ],
  input  logic [DATA_WIDTH-1:0]  req_wdata [N_REQ],
  input  logic [WORDS-1:0]       req_wmask [N_REQ],
  // read response
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  // init sweep control
  input  logic                   init_start,
  output logic                   init_busy,
  output logic                   init_done,
  // data array side
  output logic [WAYS-1:0]        arr_read_req,
  output logic [INDEX_WIDTH-1:0] arr_read_index,
  output logic                   arr_write_en,
  output logic [INDEX_WIDTH-1:0] arr_write_index,
  output logic [WAYS-1:0]        arr_write_way,
  output logic [DATA_WIDTH-1:0]  arr_write_data,
  output logic [63:0]            arr_write_mask,
  input  logic [DATA_WIDTH-1:0]  arr_read_data [WAYS]
);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_init = 1'b1;

  localparam logic [INDEX_WIDTH-1:0] c_set_last = '1;
  localparam logic [ID_W-1:0]        c_last_id  = ID_W'(N_REQ - 1);

  logic [0:0]             r_state;
  logic [INDEX_WIDTH-1:0] r_set_cnt;
  logic [ID_W-1:0]        r_rr_ptr;
  logic                   r_rsp_valid;
  logic [WAY_W-1:0]       r_way_q;
  logic [ID_W-1:0]        r_id_q;

  logic [ID_W-1:0]        w_cand [N_REQ];
  logic                   w_found;
  logic [ID_W-1:0]        w_grant;
  logic [ID_W-1:0]        w_rr_next;
  logic                   w_arb_en;
  logic                   w_hs;
  logic                   w_do_write;
  logic                   w_do_read;

  // Search order for this cycle: requester ids starting at rr_ptr, wrapping.
  for (genvar i = 0; i < N_REQ; i++) begin : g_cand
    assign w_cand[i] = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
  end

  // Pick the first valid requester in round-robin order.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[w_cand[i]]) begin
        w_found = 1'b1;
        w_grant = w_cand[i];
      end
    end
  end

  // A pending init_start wins over every requester in the same cycle.
  assign w_arb_en   = (r_state == c_idle) && !init_start;
  assign w_hs       = w_arb_en && w_found;
  assign w_do_write = w_hs && req_write[w_grant];
  assign w_do_read  = w_hs && !req_write[w_grant];
  assign w_rr_next  = (w_grant == c_last_id) ? '0 : w_grant + 1'b1;
  assign req_ready  = w_hs ? (N_REQ'(1) << w_grant) : '0;

  // Array port drive: sweep writes during INIT, otherwise the winner's op.
  always_comb begin
    arr_read_req    = '0;
    arr_read_index  = req_index[w_grant];
    arr_write_en    = 1'b0;
    arr_write_index = req_index[w_grant];
    arr_write_way   = '0;
    arr_write_data  = req_wdata[w_grant];
    arr_write_mask  = 64'(req_wmask[w_grant]);
    if (r_state == c_init) begin
      arr_write_en    = 1'b1;
      arr_write_index = r_set_cnt;
      arr_write_way   = '1;
      arr_write_data  = '0;
      arr_write_mask  = 64'({WORDS{1'b1}});
    end else if (w_do_write) begin
      arr_write_en    = 1'b1;
      arr_write_way   = WAYS'(1) << req_way[w_grant];
    end
    if (w_do_read) begin
      arr_read_req    = WAYS'(1) << req_way[w_grant];
    end
  end

  // Sequencer state, sweep counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_set_cnt <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (init_start) begin
            r_state   <= c_init;
            r_set_cnt <= '0;
          end else if (w_hs) begin
            r_rr_ptr  <= w_rr_next;
          end
        end
        c_init: begin
          r_set_cnt <= r_set_cnt + 1'b1;
          if (r_set_cnt == c_set_last) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Read response pipe: remember way and requester for the array's next-cycle data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_way_q     <= '0;
      r_id_q      <= '0;
    end else begin
      r_rsp_valid <= w_do_read;
      if (w_do_read) begin
        r_way_q <= req_way[w_grant];
        r_id_q  <= w_grant;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id_q;
  assign rsp_data  = arr_read_data[r_way_q];
  assign init_busy = (r_state == c_init);
  assign init_done = (r_state == c_init) && (r_set_cnt == c_set_last);

endmodule
`default_nettype wire
